// File: rtl/imem_noc_slice_pkg.sv
// imem_noc_slice_pkg: shared configuration, payload types and skid-buffer state encoding.
//   urv_cfg            : build-time configuration (IMEM_NOC_MAX_OUTS).
//   urv_typedef        : fetch request/response payload structs.
//   imem_noc_slice_pkg : payload widths and the skid buffer state enum.
package urv_cfg;
    localparam int IMEM_NOC_MAX_OUTS = 2;
endpackage

package urv_typedef;
    typedef struct packed {
        logic [31:0] addr;
    } mem_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        resp_last;
    } mem_resp_t;
endpackage

package imem_noc_slice_pkg;
    import urv_typedef::*;
    localparam int REQ_W  = $bits(mem_req_t);
    localparam int RESP_W = $bits(mem_resp_t);
    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;
endpackage

// File: rtl/noc_skid_buf2.sv
// noc_skid_buf2: 2-entry ready/valid skid buffer, FIFO order, 1-cycle latency, full throughput.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake (in_ready = not FULL, from state register)
//   in_data              : upstream payload
//   out_valid/out_ready  : downstream handshake (out_valid = not EMPTY, from state register)
//   out_data             : oldest buffered entry
module noc_skid_buf2
    import imem_noc_slice_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_e state, state_nxt;
    logic [W-1:0] d0, d1;
    logic push, pop;

    assign in_ready  = state != SKID_FULL;
    assign out_valid = state != SKID_EMPTY;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = d0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= SKID_EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SKID_EMPTY: state_nxt = push ? SKID_ONE : SKID_EMPTY;
            SKID_ONE:   state_nxt = (push && !pop) ? SKID_FULL : (pop && !push) ? SKID_EMPTY : SKID_ONE;
            SKID_FULL:  state_nxt = pop ? SKID_ONE : SKID_FULL;
            default:    state_nxt = SKID_EMPTY;
        endcase
    end

    // d0 is always the head; d1 only holds the second entry while FULL.
    always_ff @(posedge clk) begin
        if (push && (state == SKID_EMPTY || (state == SKID_ONE && pop))) d0 <= in_data;
        else if (pop && state == SKID_FULL)                               d0 <= d1;
        if (push && state == SKID_ONE && !pop) d1 <= in_data;
    end
endmodule

// File: rtl/imem_noc_slice.sv
// imem_noc_slice: flow-control slice between instruction fetch and the imem NoC router master port.
//   Registers requests (and, by default, responses) in 2-entry skid buffers and caps
//   in-flight fetches at MAX_OUTS; a fetch retires on the upstream resp_last handshake.
//   Macro IMEM_NOC_SLICE_RESP_BYPASS_EN: response channel becomes a 0-latency pass-through.
//   clk, rstn                          : clock, asynchronous active-low reset
//   up_req_valid/up_req_ready/up_req   : request from fetch
//   up_resp_valid/up_resp_ready/up_resp: response beats to fetch
//   dn_req_valid/dn_req_ready/dn_req   : request to router
//   dn_resp_valid/dn_resp_ready/dn_resp: response beats from router
//   outs_cnt                           : outstanding fetch count
//   idle                               : buffers empty and nothing outstanding
module imem_noc_slice
    import urv_cfg::*;
    import urv_typedef::*;
    import imem_noc_slice_pkg::*;
#(
    parameter int MAX_OUTS = IMEM_NOC_MAX_OUTS,
    parameter int CNT_W    = $clog2(MAX_OUTS + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              up_req_valid,
    output logic              up_req_ready,
    input  logic [REQ_W-1:0]  up_req,
    output logic              up_resp_valid,
    input  logic              up_resp_ready,
    output logic [RESP_W-1:0] up_resp,
    output logic              dn_req_valid,
    input  logic              dn_req_ready,
    output logic [REQ_W-1:0]  dn_req,
    input  logic              dn_resp_valid,
    output logic              dn_resp_ready,
    input  logic [RESP_W-1:0] dn_resp,
    output logic [CNT_W-1:0]  outs_cnt,
    output logic              idle
);
    logic rq_valid, credit, inc, last_hs, dec, resp_empty;
    mem_resp_t up_resp_s;

    // Credit uses only the registered count, so a retiring fetch frees its slot next cycle.
    assign credit       = outs_cnt < CNT_W'(MAX_OUTS);
    assign dn_req_valid = rq_valid && credit;

    noc_skid_buf2 #(.W(REQ_W)) u_req_buf (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (up_req_valid),
        .in_ready  (up_req_ready),
        .in_data   (up_req),
        .out_valid (rq_valid),
        .out_ready (dn_req_ready && credit),
        .out_data  (dn_req)
    );

`ifdef IMEM_NOC_SLICE_RESP_BYPASS_EN
    assign up_resp_valid = dn_resp_valid;
    assign up_resp       = dn_resp;
    assign dn_resp_ready = up_resp_ready;
    assign resp_empty    = 1'b1;
`else
    noc_skid_buf2 #(.W(RESP_W)) u_resp_buf (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (dn_resp_valid),
        .in_ready  (dn_resp_ready),
        .in_data   (dn_resp),
        .out_valid (up_resp_valid),
        .out_ready (up_resp_ready),
        .out_data  (up_resp)
    );
    assign resp_empty = !up_resp_valid;
`endif

    assign up_resp_s = mem_resp_t'(up_resp);
    assign inc       = dn_req_valid && dn_req_ready;
    assign last_hs   = up_resp_valid && up_resp_ready && up_resp_s.resp_last;
    // A stray resp_last with nothing outstanding must not wrap the counter.
    assign dec       = last_hs && outs_cnt != '0;
    assign idle      = !rq_valid && resp_empty && outs_cnt == '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            outs_cnt <= '0;
        else if (inc && !dec) outs_cnt <= outs_cnt + CNT_W'(1);
        else if (dec && !inc) outs_cnt <= outs_cnt - CNT_W'(1);
    end

    a_no_stray_last: assert property (@(posedge clk) disable iff (!rstn) !(last_hs && outs_cnt == '0));
endmodule

// File: tb/tb_imem_noc_slice.sv
// tb_imem_noc_slice: randomized bench for imem_noc_slice against a queue-based reference model.
module tb_imem_noc_slice;
    import urv_cfg::*;
    import urv_typedef::*;
    import imem_noc_slice_pkg::*;

    localparam int MAX = IMEM_NOC_MAX_OUTS;
    localparam int CW  = $clog2(MAX + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              up_req_valid, up_req_ready;
    logic [REQ_W-1:0]  up_req;
    logic              up_resp_valid, up_resp_ready;
    logic [RESP_W-1:0] up_resp;
    logic              dn_req_valid, dn_req_ready;
    logic [REQ_W-1:0]  dn_req;
    logic              dn_resp_valid, dn_resp_ready;
    logic [RESP_W-1:0] dn_resp;
    logic [CW-1:0]     outs_cnt;
    logic              idle;

    imem_noc_slice dut (
        .clk           (clk),
        .rstn          (rstn),
        .up_req_valid  (up_req_valid),
        .up_req_ready  (up_req_ready),
        .up_req        (up_req),
        .up_resp_valid (up_resp_valid),
        .up_resp_ready (up_resp_ready),
        .up_resp       (up_resp),
        .dn_req_valid  (dn_req_valid),
        .dn_req_ready  (dn_req_ready),
        .dn_req        (dn_req),
        .dn_resp_valid (dn_resp_valid),
        .dn_resp_ready (dn_resp_ready),
        .dn_resp       (dn_resp),
        .outs_cnt      (outs_cnt),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of each buffer, fetches in flight, and the emulated router.
    logic [REQ_W-1:0]  req_q[$];
    logic [RESP_W-1:0] resp_q[$];
    int                mcnt;
    logic [31:0]       rt_addr[$];
    int                rt_beats[$];
    int                rt_bi;
    logic [31:0]       next_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        req_q.delete();
        resp_q.delete();
        rt_addr.delete();
        rt_beats.delete();
        rt_bi = 0;
        mcnt = 0;
    endtask

    task automatic drive(input int pv, input int pr, input int prv, input int pur);
        mem_resp_t r;
        up_req_valid  = $urandom_range(99) < pv;
        up_req        = next_addr;
        dn_req_ready  = $urandom_range(99) < pr;
        up_resp_ready = $urandom_range(99) < pur;
        dn_resp_valid = rt_addr.size() > 0 && $urandom_range(99) < prv;
        r = '0;
        if (rt_addr.size() > 0) begin
            r.rdata     = rt_addr[0] ^ (32'(rt_bi) << 28);
            r.resp_last = rt_bi == rt_beats[0] - 1;
        end
        dn_resp = r;
    endtask

    task automatic step();
        bit eur, edv, euv, edr;
        logic [RESP_W-1:0] head;
        mem_resp_t hs;
        eur = req_q.size() < 2;
        edv = req_q.size() > 0 && mcnt < MAX;
        check("up_req_ready", up_req_ready, eur);
        check("dn_req_valid", dn_req_valid, edv);
        if (edv) check("dn_req", dn_req, req_q[0]);
`ifdef IMEM_NOC_SLICE_RESP_BYPASS_EN
        euv  = dn_resp_valid;
        edr  = up_resp_ready;
        head = dn_resp;
`else
        euv  = resp_q.size() > 0;
        edr  = resp_q.size() < 2;
        head = euv ? resp_q[0] : '0;
`endif
        check("up_resp_valid", up_resp_valid, euv);
        check("dn_resp_ready", dn_resp_ready, edr);
        if (euv) check("up_resp", up_resp, head);
        check("outs_cnt", outs_cnt, mcnt);
        check("idle", idle, req_q.size() == 0 && resp_q.size() == 0 && mcnt == 0);
        hs = mem_resp_t'(head);
        if (euv && up_resp_ready) begin
            if (hs.resp_last) mcnt--;
`ifndef IMEM_NOC_SLICE_RESP_BYPASS_EN
            void'(resp_q.pop_front());
`endif
        end
        if (dn_resp_valid && edr) begin
`ifndef IMEM_NOC_SLICE_RESP_BYPASS_EN
            resp_q.push_back(dn_resp);
`endif
            if (rt_bi == rt_beats[0] - 1) begin
                void'(rt_addr.pop_front());
                void'(rt_beats.pop_front());
                rt_bi = 0;
            end else rt_bi++;
        end
        if (edv && dn_req_ready) begin
            rt_addr.push_back(req_q.pop_front());
            rt_beats.push_back($urandom_range(1, 4));
            mcnt++;
        end
        if (up_req_valid && eur) begin
            req_q.push_back(up_req);
            next_addr += 32'd4;
        end
    endtask

    task automatic run(input int n, input int pv, input int pr, input int prv, input int pur);
        for (int i = 0; i < n; i++) begin
            drive(pv, pr, prv, pur);
            @(negedge clk);
            step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_up_req_ready"}, up_req_ready, 1'b1);
        check({tag, "_dn_req_valid"}, dn_req_valid, 1'b0);
        check({tag, "_up_resp_valid"}, up_resp_valid, 1'b0);
        check({tag, "_dn_resp_ready"}, dn_resp_ready, 1'b1);
        check({tag, "_outs_cnt"}, outs_cnt, '0);
        check({tag, "_idle"}, idle, 1'b1);
    endtask

    task automatic quiet_inputs();
        up_req_valid  = 1'b0;
        dn_resp_valid = 1'b0;
        up_resp_ready = 1'b1;
        dn_req_ready  = 1'b0;
    endtask

    initial begin
        next_addr = 32'h10;
        model_clear();
        rstn = 1'b0;
        quiet_inputs();
        up_req  = '0;
        dn_resp = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst");
        rstn = 1'b1;
        run(4, 100, 100, 100, 100);
        run(6, 0, 100, 100, 100);
        run(8, 100, 0, 0, 100);
        run(10, 100, 100, 0, 100);
        run(12, 0, 100, 100, 50);
        run(20, 100, 100, 100, 100);
        for (int p = 0; p < 30; p++)
            run(40, $urandom_range(100), $urandom_range(100), $urandom_range(100), $urandom_range(100));
        run(12, 100, 100, 100, 0);
        quiet_inputs();
        #2;
        rstn = 1'b0;
        #1;
        reset_checks("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run(60, 70, 70, 70, 70);
        for (int k = 0; k < 40 && (req_q.size() > 0 || mcnt > 0 || resp_q.size() > 0); k++)
            run(10, 0, 100, 100, 100);
        check("drain_idle", idle, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
